dec_controller: RTL

- Generates the 31-bit `dec` value consumed by the timer cluster.
- `dec` shortens every timer period, which raises game speed as play progresses.
- Steps `dec` up on accumulated kill events or elapsed level ticks, saturates at a ceiling, and reports the current level.
- Sits between game logic (kill/start/over strobes, a 1 Hz tick from a timer output) and the timer cluster `dec` input.

---
 rtl/dec_controller_if.sv | 24 ++
 rtl/dec_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dec_controller_if.sv
// Strobe inputs and level/decrement outputs exchanged between game logic and
// the decrement controller.
interface dec_controller_if;
  logic        start;
  logic        over;
  logic        kill;
  logic        tick;
  logic [30:0] dec;
  logic [7:0]  level;
  logic        level_up;
  logic        at_max;

  // Game logic drives the strobes and observes the controller state.
  modport master (
    output start, over, kill, tick,
    input  dec, level, level_up, at_max
  );

  // The controller samples the strobes and drives the registered results.
  modport slave (
    input  start, over, kill, tick,
    output dec, level, level_up, at_max
  );
endinterface

// File: rtl/dec_controller.sv
// Difficulty controller: raises the timer-period decrement in fixed steps after
// enough kills or ticks, saturating at a ceiling and reporting the level.
module dec_controller #(
  parameter int unsigned DEC_STEP       = 2_000_000,
  parameter int unsigned DEC_MAX        = 80_000_000,
  parameter int unsigned KILLS_PER_STEP = 10,
  parameter int unsigned TICKS_PER_STEP = 30
) (
  input  logic             clk,
  input  logic             rst,
  dec_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  localparam logic [31:0] DEC_STEP_W = 32'(DEC_STEP);
  localparam logic [31:0] DEC_MAX_W  = 32'(DEC_MAX);
  localparam logic [30:0] DEC_MAX_31 = DEC_MAX_W[30:0];
  localparam logic [8:0]  KILL_THR   = 9'(KILLS_PER_STEP);
  localparam logic [8:0]  TICK_THR   = 9'(TICKS_PER_STEP);
  localparam logic [7:0]  LEVEL_TOP  = 8'd255;

  state_e      state_q,    state_d;
  logic [30:0] dec_q,      dec_d;
  logic [7:0]  level_q,    level_d;
  logic        level_up_q, level_up_d;
  logic        at_max_q,   at_max_d;
  logic [7:0]  kill_cnt_q, kill_cnt_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;

  logic [8:0]  kill_sum;
  logic [8:0]  tick_sum;
  logic        trigger;
  logic [31:0] step_sum;
  logic [30:0] step_dec;
  logic        below_max;

  // Counts include the strobe of the current cycle so the step lands on the
  // same edge that samples the threshold-reaching strobe.
  assign kill_sum  = {1'b0, kill_cnt_q} + {8'd0, bus.kill};
  assign tick_sum  = {1'b0, tick_cnt_q} + {8'd0, bus.tick};
  assign trigger   = (kill_sum >= KILL_THR) || (tick_sum >= TICK_THR);

  // 32-bit sum cannot wrap for any legal DEC_MAX below 2^31.
  assign step_sum  = {1'b0, dec_q} + DEC_STEP_W;
  assign step_dec  = (step_sum >= DEC_MAX_W) ? DEC_MAX_31 : step_sum[30:0];
  assign below_max = (dec_q < DEC_MAX_31);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    dec_d      = dec_q;
    level_d    = level_q;
    level_up_d = 1'b0;
    at_max_d   = at_max_q;
    kill_cnt_d = kill_cnt_q;
    tick_cnt_d = tick_cnt_q;

    if (bus.start) begin
      // Restart from any state; start also beats a simultaneous over.
      state_d    = RUN;
      dec_d      = '0;
      level_d    = '0;
      at_max_d   = 1'b0;
      kill_cnt_d = '0;
      tick_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          kill_cnt_d = '0;
          tick_cnt_d = '0;
        end

        RUN: begin
          if (bus.over) begin
            state_d    = FROZEN;
            kill_cnt_d = '0;
            tick_cnt_d = '0;
          end else if (trigger) begin
            kill_cnt_d = '0;
            tick_cnt_d = '0;
            if (below_max) begin
              dec_d      = step_dec;
              at_max_d   = (step_dec == DEC_MAX_31);
              level_up_d = 1'b1;
              level_d    = (level_q == LEVEL_TOP) ? level_q : level_q + 8'd1;
            end
          end else begin
            kill_cnt_d = kill_sum[7:0];
            tick_cnt_d = tick_sum[7:0];
          end
        end

        FROZEN: begin
          kill_cnt_d = '0;
          tick_cnt_d = '0;
        end

        default: begin
          state_d    = IDLE;
          kill_cnt_d = '0;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dec_q      <= '0;
      level_q    <= '0;
      level_up_q <= 1'b0;
      at_max_q   <= 1'b0;
      kill_cnt_q <= '0;
      tick_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // independent of statement order.
      state_q    <= state_d;
      dec_q      <= dec_d;
      level_q    <= level_d;
      level_up_q <= level_up_d;
      at_max_q   <= at_max_d;
      kill_cnt_q <= kill_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign bus.dec      = dec_q;
  assign bus.level    = level_q;
  assign bus.level_up = level_up_q;
  assign bus.at_max   = at_max_q;

endmodule
